// File: rtl/io_request_controller_if.sv
// rtl/io_request_controller_if.sv - decode/register-file/peripheral signal bundle for io_request_controller
//
// Purpose: groups every non-clock signal of the IO request controller.
// Modports:
//   master - the controller: takes decode, register and peripheral inputs and
//            drives the peripheral request, pipeline stall and register write.
//   slave  - the surrounding pipeline and peripheral (the opposite directions).
// Signals:
//   Op_In, Op_Out        decoded IN / OUT instruction present
//   Write_Data[31:0]     signed register value to display (OUT)
//   Dest_Reg[4:0]        destination register (IN)
//   Interrupt            peripheral waiting/confirm handshake
//   Data_In[31:0]        signed value latched by the peripheral
//   Enable, IO           peripheral request and direction (1 = output)
//   Data_Out[31:0]       signed value sent to the peripheral
//   Stall                pipeline hold
//   Reg_Write            one-cycle register-file write strobe
//   Reg_Addr[4:0]        write address
//   Reg_Data[31:0]       write data
//   Timeout              one-cycle pulse when an IN is aborted
interface io_request_controller_if;
  logic        Op_In;
  logic        Op_Out;
  logic [31:0] Write_Data;
  logic [4:0]  Dest_Reg;
  logic        Interrupt;
  logic [31:0] Data_In;
  logic        Enable;
  logic        IO;
  logic [31:0] Data_Out;
  logic        Stall;
  logic        Reg_Write;
  logic [4:0]  Reg_Addr;
  logic [31:0] Reg_Data;
  logic        Timeout;

  modport master (
    input  Op_In, Op_Out, Write_Data, Dest_Reg, Interrupt, Data_In,
    output Enable, IO, Data_Out, Stall, Reg_Write, Reg_Addr, Reg_Data, Timeout
  );

  modport slave (
    output Op_In, Op_Out, Write_Data, Dest_Reg, Interrupt, Data_In,
    input  Enable, IO, Data_Out, Stall, Reg_Write, Reg_Addr, Reg_Data, Timeout
  );
endinterface

// File: rtl/io_request_controller.sv
// rtl/io_request_controller.sv - processor-side initiator for the switch/7-segment IO peripheral
//
// Purpose: turns decoded IN/OUT instructions into Enable/IO/Data_Out requests,
// stalls the pipeline until the request completes and, for IN, follows the
// peripheral's Interrupt handshake before writing the captured value back.
// Ports:
//   Slow_Clock  system clock, all state updates on its rising edge
//   Reset       asynchronous, active-high reset
//   bus         io_request_controller_if.master (decode, register file and
//               peripheral signals; see the interface file)
// Parameters:
//   OUT_HOLD_CYCLES  cycles Enable stays high for an OUT (>= 1)
//   TIMEOUT_CYCLES   maximum IN wait cycles before abort (IO_TIMEOUT_EN only)
// Build option:
//   IO_TIMEOUT_EN    when defined, an IN that waits TIMEOUT_CYCLES is aborted
//                    with a zero register write and a Timeout pulse; when not
//                    defined, IN waits indefinitely and Timeout is tied low.
module io_request_controller #(
  parameter int OUT_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic                    Slow_Clock,
  input logic                    Reset,
  io_request_controller_if.master bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] OUT_HOLD   = 3'd1;
  localparam logic [2:0] IN_ARM     = 3'd2;
  localparam logic [2:0] IN_WAIT    = 3'd3;
  localparam logic [2:0] IN_CAPTURE = 3'd4;

  localparam int              HOLD_W    = (OUT_HOLD_CYCLES < 2) ? 1 : $clog2(OUT_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OUT_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [2:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              wait_expired;

`ifdef IO_TIMEOUT_EN
  localparam int               WAIT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  // wait_cnt holds the number of completed wait cycles, so the cycle in which
  // it equals TIMEOUT_CYCLES-1 is the last one allowed.
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE && bus.Op_In) begin
      wait_cnt <= '0;
    end else if (state == IN_ARM || state == IN_WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Abort only if the peripheral has not completed on this same edge; a
  // falling Interrupt in IN_WAIT takes priority over the timeout.
  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wait_expired &&
                   ((state == IN_ARM) || (state == IN_WAIT && bus.Interrupt));
    end
  end

  assign bus.Timeout = timeout_q;
`else
  // TIMEOUT_CYCLES only matters with the abort logic; referenced here so the
  // parameter list stays identical in both builds.
  localparam logic TIMEOUT_PARAM_SEEN = (TIMEOUT_CYCLES > 0);

  assign wait_expired = 1'b0;
  assign bus.Timeout  = TIMEOUT_PARAM_SEEN & 1'b0;
`endif

  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      bus.Data_Out <= '0;
      bus.Reg_Addr <= '0;
      bus.Reg_Data <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Op_In has priority; decode should never raise both.
          if (bus.Op_In) begin
            bus.Reg_Addr <= bus.Dest_Reg;
            state        <= IN_ARM;
          end else if (bus.Op_Out) begin
            bus.Data_Out <= bus.Write_Data;
            hold_cnt     <= HOLD_LOAD;
            state        <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          hold_cnt <= hold_cnt - HOLD_ONE;
          if (hold_cnt == HOLD_ONE) begin
            state <= IDLE;
          end
        end
        IN_ARM: begin
          // A low Interrupt here is left over from before the request and
          // must not be read as completion; wait for it to rise first.
          if (wait_expired) begin
            bus.Reg_Data <= '0;
            state        <= IN_CAPTURE;
          end else if (bus.Interrupt) begin
            state <= IN_WAIT;
          end
        end
        IN_WAIT: begin
          if (!bus.Interrupt) begin
            bus.Reg_Data <= bus.Data_In;
            state        <= IN_CAPTURE;
          end else if (wait_expired) begin
            bus.Reg_Data <= '0;
            state        <= IN_CAPTURE;
          end
        end
        IN_CAPTURE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Enable    = (state == OUT_HOLD) || (state == IN_ARM) || (state == IN_WAIT);
  assign bus.IO        = (state == OUT_HOLD);
  assign bus.Reg_Write = (state == IN_CAPTURE);

  // Stall drops in the final OUT_HOLD cycle and in IN_CAPTURE so the
  // pipeline advances on the same edge the operation completes.
  always_comb begin
    bus.Stall = 1'b0;
    case (state)
      IDLE:     bus.Stall = bus.Op_In || bus.Op_Out;
      OUT_HOLD: bus.Stall = (hold_cnt > HOLD_ONE);
      IN_ARM:   bus.Stall = 1'b1;
      IN_WAIT:  bus.Stall = 1'b1;
      default:  bus.Stall = 1'b0;
    endcase
    if (Reset) begin
      bus.Stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_io_request_controller.sv
// tb/tb_io_request_controller.sv - directed vector bench for io_request_controller
module tb_io_request_controller;

  logic Slow_Clock;
  logic Reset;

  io_request_controller_if bus ();

  io_request_controller #(
    .OUT_HOLD_CYCLES(2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .Slow_Clock(Slow_Clock),
    .Reset     (Reset),
    .bus       (bus.master)
  );

  initial Slow_Clock = 1'b0;
  always #5 Slow_Clock = ~Slow_Clock;

  typedef struct {
    logic        rst;
    logic        op_in;
    logic        op_out;
    logic [31:0] wd;
    logic [4:0]  dr;
    logic        intr;
    logic [31:0] din;
    logic        en;
    logic        io;
    logic        stall;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] dout;
    logic        to;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int applied;
  int miscompares;

  function automatic vec_t mk(
    input logic rst, input logic op_in, input logic op_out, input logic [31:0] wd,
    input logic [4:0] dr, input logic intr, input logic [31:0] din,
    input logic en, input logic io, input logic stall, input logic rw,
    input logic [4:0] ra, input logic [31:0] rd, input logic [31:0] dout);
    vec_t v;
    v.rst = rst; v.op_in = op_in; v.op_out = op_out; v.wd = wd; v.dr = dr;
    v.intr = intr; v.din = din; v.en = en; v.io = io; v.stall = stall;
    v.rw = rw; v.ra = ra; v.rd = rd; v.dout = dout; v.to = 1'b0;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic op_in, input logic op_out,
                       input logic [31:0] wd, input logic [4:0] dr,
                       input logic intr, input logic [31:0] din);
    @(posedge Slow_Clock);
    #1;
    Reset          = rst;
    bus.Op_In      = op_in;
    bus.Op_Out     = op_out;
    bus.Write_Data = wd;
    bus.Dest_Reg   = dr;
    bus.Interrupt  = intr;
    bus.Data_In    = din;
    @(negedge Slow_Clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic ok;

  initial begin
    applied     = 0;
    miscompares = 0;
    Reset          = 1'b1;
    bus.Op_In      = 1'b0;
    bus.Op_Out     = 1'b0;
    bus.Write_Data = '0;
    bus.Dest_Reg   = '0;
    bus.Interrupt  = 1'b0;
    bus.Data_In    = '0;

    //              rst op_in op_out wd            dr     intr din           en io st rw ra     rd            dout
    vecs[0]  = mk(1, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 0, 5'd0, 32'h0,         32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 0, 5'd0, 32'h0,         32'h0);
    // OUT with hold of two cycles
    vecs[2]  = mk(0, 0, 1, 32'h1234_ABCD, 5'd0, 0, 32'h0,         0, 0, 1, 0, 5'd0, 32'h0,         32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 1, 1, 0, 5'd0, 32'h0,         32'h1234_ABCD);
    vecs[4]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 1, 0, 0, 5'd0, 32'h0,         32'h1234_ABCD);
    vecs[5]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 0, 5'd0, 32'h0,         32'h1234_ABCD);
    // IN to r7: stale low Interrupt for 4 cycles, high 3 cycles, then low with -5
    vecs[6]  = mk(0, 1, 0, 32'h0,         5'd7, 0, 32'h0,         0, 0, 1, 0, 5'd0, 32'h0,         32'h1234_ABCD);
    vecs[7]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[8]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[9]  = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[10] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[11] = mk(0, 0, 0, 32'h0,         5'd0, 1, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[12] = mk(0, 0, 0, 32'h0,         5'd0, 1, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[13] = mk(0, 0, 0, 32'h0,         5'd0, 1, 32'h0,         1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[14] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'hFFFF_FFFB, 1, 0, 1, 0, 5'd7, 32'h0,         32'h1234_ABCD);
    vecs[15] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 1, 5'd7, 32'hFFFF_FFFB, 32'h1234_ABCD);
    vecs[16] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 0, 5'd7, 32'hFFFF_FFFB, 32'h1234_ABCD);
    // both ops together: IN wins, ops held high afterwards are ignored
    vecs[17] = mk(0, 1, 1, 32'hDEAD_BEEF, 5'd3, 0, 32'h0,         0, 0, 1, 0, 5'd7, 32'hFFFF_FFFB, 32'h1234_ABCD);
    vecs[18] = mk(0, 1, 1, 32'hDEAD_BEEF, 5'd9, 1, 32'h0,         1, 0, 1, 0, 5'd3, 32'hFFFF_FFFB, 32'h1234_ABCD);
    vecs[19] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0000_0042, 1, 0, 1, 0, 5'd3, 32'hFFFF_FFFB, 32'h1234_ABCD);
    vecs[20] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 1, 5'd3, 32'h0000_0042, 32'h1234_ABCD);
    // IN to r9, reset while in IN_WAIT
    vecs[21] = mk(0, 1, 0, 32'h0,         5'd9, 0, 32'h0,         0, 0, 1, 0, 5'd3, 32'h0000_0042, 32'h1234_ABCD);
    vecs[22] = mk(0, 0, 0, 32'h0,         5'd0, 1, 32'h0,         1, 0, 1, 0, 5'd9, 32'h0000_0042, 32'h1234_ABCD);
    vecs[23] = mk(0, 0, 0, 32'h0,         5'd0, 1, 32'h0,         1, 0, 1, 0, 5'd9, 32'h0000_0042, 32'h1234_ABCD);
    vecs[24] = mk(1, 1, 0, 32'h0,         5'd0, 1, 32'h0,         0, 0, 0, 0, 5'd0, 32'h0,         32'h0);
    vecs[25] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0000_0077, 0, 0, 0, 0, 5'd0, 32'h0,         32'h0);
    vecs[26] = mk(0, 0, 0, 32'h0,         5'd0, 0, 32'h0,         0, 0, 0, 0, 5'd0, 32'h0,         32'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].op_in, vecs[i].op_out, vecs[i].wd,
            vecs[i].dr, vecs[i].intr, vecs[i].din);
      applied++;
      if (bus.Enable !== vecs[i].en || bus.IO !== vecs[i].io ||
          bus.Stall !== vecs[i].stall || bus.Reg_Write !== vecs[i].rw ||
          bus.Reg_Addr !== vecs[i].ra || bus.Reg_Data !== vecs[i].rd ||
          bus.Data_Out !== vecs[i].dout || bus.Timeout !== vecs[i].to) begin
        miscompares++;
        $display("FAIL vec%0d: got en=%b io=%b stall=%b rw=%b ra=%0d rd=%h dout=%h to=%b, expected en=%b io=%b stall=%b rw=%b ra=%0d rd=%h dout=%h to=%b",
                 i, bus.Enable, bus.IO, bus.Stall, bus.Reg_Write, bus.Reg_Addr,
                 bus.Reg_Data, bus.Data_Out, bus.Timeout,
                 vecs[i].en, vecs[i].io, vecs[i].stall, vecs[i].rw, vecs[i].ra,
                 vecs[i].rd, vecs[i].dout, vecs[i].to);
      end
    end

`ifdef IO_TIMEOUT_EN
    // Interrupt falls on the edge the 8th wait cycle ends: normal completion
    drive(0, 1, 0, 32'h0, 5'd6, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 5'd0, 1, 32'h0);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 32'h0, 5'd0, 1, 32'h0);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'd123);
    check("race_stall_before_edge", {31'd0, bus.Stall}, 32'd1);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0);
    check("race_timeout", {31'd0, bus.Timeout}, 32'd0);
    check("race_reg_write", {31'd0, bus.Reg_Write}, 32'd1);
    check("race_reg_data", bus.Reg_Data, 32'd123);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0);

    // Interrupt stuck low: abort after 8 wait cycles with a zero write
    drive(0, 1, 0, 32'h0, 5'd4, 0, 32'h0);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0000_5555);
      ok = ok & bus.Stall & bus.Enable & ~bus.Reg_Write & ~bus.Timeout;
    end
    check("timeout_wait_cycles", {31'd0, ok}, 32'd1);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0000_5555);
    check("timeout_pulse", {31'd0, bus.Timeout}, 32'd1);
    check("timeout_reg_write", {31'd0, bus.Reg_Write}, 32'd1);
    check("timeout_reg_data", bus.Reg_Data, 32'd0);
    check("timeout_reg_addr", {27'd0, bus.Reg_Addr}, 32'd4);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0);
    check("timeout_pulse_end", {31'd0, bus.Timeout}, 32'd0);
`else
    // Without the abort logic an IN waits as long as the peripheral takes
    drive(0, 1, 0, 32'h0, 5'd2, 0, 32'h0);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0000_5555);
      ok = ok & bus.Stall & bus.Enable & ~bus.Reg_Write & ~bus.Timeout;
    end
    check("long_wait_holds", {31'd0, ok}, 32'd1);
    drive(0, 0, 0, 32'h0, 5'd0, 1, 32'h0);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'hFFFF_FF9C);
    drive(0, 0, 0, 32'h0, 5'd0, 0, 32'h0);
    check("long_wait_reg_write", {31'd0, bus.Reg_Write}, 32'd1);
    check("long_wait_reg_data", bus.Reg_Data, 32'hFFFF_FF9C);
    check("long_wait_reg_addr", {27'd0, bus.Reg_Addr}, 32'd2);
    check("long_wait_timeout", {31'd0, bus.Timeout}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
